conv_window_streamer: RTL and testbench

- Parametrised successor to the fixed 3-RAM, 9x9, stride-2 line-buffer front end of the conv/dense pipeline.
- Accepts a raster-order pixel stream and emits each KxK convolution window, at a configurable stride, as one flattened word.
- Uses K-1 internal line buffers and a KxK register window, with valid/ready handshakes on both sides.
- Sits between the pixel source and the parallel conv/ReLU units.

---
 rtl/conv_window_streamer.sv | 148 ++++++++++++++
 tb/tb_conv_window_streamer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_streamer.sv
// Raster pixel stream to KxK convolution windows at a configurable stride.
// K-1 line buffers feed a KxK register window; a single output register holds each window until consumed.
module conv_window_streamer #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 9,
    parameter int IMG_H  = 9,
    parameter int K      = 3,
    parameter int STRIDE = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     in_pixel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [K*K*DATA_W-1:0] out_window,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  frame_done,
    output logic [1:0]            fsm_state
);

    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int PH_W   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int OUT_WN = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_HN = (IMG_H - K) / STRIDE + 1;
    localparam int LAST_C = K - 1 + (OUT_WN - 1) * STRIDE;
    localparam int LAST_R = K - 1 + (OUT_HN - 1) * STRIDE;

    typedef enum logic [1:0] {FILL = 2'd0, STREAM = 2'd1, WRAP = 2'd2} state_t;

    state_t state_q, state_d;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [PH_W-1:0]   col_ph, row_ph;
    logic [DATA_W-1:0] lb [K-1][IMG_W];
    logic [DATA_W-1:0] win [K][K];
    logic [DATA_W-1:0] win_next [K][K];
    logic [DATA_W-1:0] new_col [K];
    logic [K*K*DATA_W-1:0] win_flat;

    logic accept, col_last, row_last, col_ok, row_ok, emit, at_last_pos;

    // Handshake: a pixel moves when in_valid && in_ready; a window moves when out_valid && out_ready.
    // in_ready is combinational so a consumed window can be replaced in the same cycle.
    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign col_last    = (col == COL_W'(IMG_W - 1));
    assign row_last    = (row == ROW_W'(IMG_H - 1));
    assign col_ok      = (col >= COL_W'(K - 1));
    assign row_ok      = (row >= ROW_W'(K - 1));
    assign emit        = accept && col_ok && row_ok && (col_ph == '0) && (row_ph == '0);
    assign at_last_pos = (row == ROW_W'(LAST_R)) && (col == COL_W'(LAST_C));
    assign frame_done  = (state_q == WRAP);
    assign fsm_state   = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            col    <= '0;
            row    <= '0;
            col_ph <= '0;
            row_ph <= '0;
        end else if (accept) begin
            if (col_last) begin
                col    <= '0;
                col_ph <= '0;
                if (row_last) begin
                    row    <= '0;
                    row_ph <= '0;
                end else begin
                    row <= row + 1'b1;
                    if (row_ok)
                        row_ph <= (row_ph == PH_W'(STRIDE - 1)) ? '0 : row_ph + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
                if (col_ok)
                    col_ph <= (col_ph == PH_W'(STRIDE - 1)) ? '0 : col_ph + 1'b1;
            end
        end
    end

    // Buffers are never cleared; row >= K-1 gating keeps old-frame rows out of emitted windows.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < K - 2; j++)
                lb[j][col] <= lb[j+1][col];
            lb[K-2][col] <= in_pixel;
        end
    end

    always_comb begin
        for (int r = 0; r < K - 1; r++)
            new_col[r] = lb[r][col];
        new_col[K-1] = in_pixel;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++)
                win_next[r][c] = win[r][c+1];
            win_next[r][K-1] = new_col[r];
        end
        win_flat = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                win_flat[(r*K+c)*DATA_W +: DATA_W] = win_next[r][c];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    win[r][c] <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_window <= '0;
        end else begin
            if (accept)
                win <= win_next;
            if (emit) begin
                out_valid  <= 1'b1;
                out_window <= win_flat;
                out_last   <= (state_q == STREAM) && at_last_pos;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= FILL;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (accept && col_last && row == ROW_W'(K - 2)) state_d = STREAM;
            STREAM:  if (accept && col_last && row_last) state_d = WRAP;
            WRAP:    state_d = FILL;
            default: state_d = FILL;
        endcase
    end

endmodule

// File: tb/tb_conv_window_streamer.sv
// Directed bench for conv_window_streamer: three geometries, scoreboard of expected windows from a ramp model.
module tb_conv_window_streamer;

    logic clk = 1'b0;
    logic reset;
    logic [2:0] iv, ordy;
    logic [15:0] ip [3];
    wire  [2:0] ir, ov, ol, fd;
    wire  [1:0] st0, st1, st2;
    wire  [143:0] ow0, ow1;
    wire  [255:0] ow2;

    int vectors = 0;
    int miscompares = 0;
    int win_idx [3] = '{0, 0, 0};
    int fd_cnt [3] = '{0, 0, 0};
    int run1 = 0;
    bit chk_last = 0;

    logic [256:0] exp_q0[$];
    logic [256:0] exp_q1[$];
    logic [256:0] exp_q2[$];

    always #5 clk = ~clk;

    conv_window_streamer #(.DATA_W(16), .IMG_W(9), .IMG_H(9), .K(3), .STRIDE(2)) dut0 (
        .clk(clk), .reset(reset), .in_pixel(ip[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .out_window(ow0), .out_valid(ov[0]), .out_ready(ordy[0]), .out_last(ol[0]),
        .frame_done(fd[0]), .fsm_state(st0));

    conv_window_streamer #(.DATA_W(16), .IMG_W(9), .IMG_H(9), .K(3), .STRIDE(1)) dut1 (
        .clk(clk), .reset(reset), .in_pixel(ip[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .out_window(ow1), .out_valid(ov[1]), .out_ready(ordy[1]), .out_last(ol[1]),
        .frame_done(fd[1]), .fsm_state(st1));

    conv_window_streamer #(.DATA_W(16), .IMG_W(8), .IMG_H(10), .K(4), .STRIDE(3)) dut2 (
        .clk(clk), .reset(reset), .in_pixel(ip[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .out_window(ow2), .out_valid(ov[2]), .out_ready(ordy[2]), .out_last(ol[2]),
        .frame_done(fd[2]), .fsm_state(st2));

    task automatic check(string tag, logic [256:0] got, logic [256:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] ow_of(int d);
        case (d)
            0:       return 256'(ow0);
            1:       return 256'(ow1);
            default: return ow2;
        endcase
    endfunction

    function automatic logic [256:0] lit9(input int v [9]);
        logic [256:0] m = '0;
        for (int i = 0; i < 9; i++) m[i*16 +: 16] = 16'(v[i]);
        return m;
    endfunction

    // Ramp frame: pixel at (row, col) has value base + row*iw + col.
    function automatic logic [256:0] model_win(int iw, int k, int r0, int c0, int base, bit last);
        logic [256:0] m = '0;
        for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++)
                m[(r*k+c)*16 +: 16] = 16'(base + (r0 + r) * iw + c0 + c);
        m[256] = last;
        return m;
    endfunction

    task automatic push_frame(int d, int iw, int ih, int k, int s, int base, int max_n);
        int ow_n = (iw - k) / s + 1;
        int oh_n = (ih - k) / s + 1;
        int n = 0;
        logic [256:0] w;
        for (int oy = 0; oy < oh_n; oy++)
            for (int ox = 0; ox < ow_n; ox++) begin
                w = model_win(iw, k, oy * s, ox * s, base, (oy == oh_n - 1) && (ox == ow_n - 1));
                if (max_n < 0 || n < max_n) begin
                    case (d)
                        0:       exp_q0.push_back(w);
                        1:       exp_q1.push_back(w);
                        default: exp_q2.push_back(w);
                    endcase
                end
                n++;
            end
    endtask

    task automatic send(int d, int p, bit gaps);
        int n = 0;
        if (gaps)
            repeat ($urandom_range(0, 1)) begin
                @(negedge clk);
                iv[d] = 1'b0;
            end
        @(negedge clk);
        iv[d] = 1'b1;
        ip[d] = 16'(p);
        #1;
        while (!ir[d] && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("in_ready_timeout", 0, 1);
    endtask

    task automatic send_range(int d, int first, int last_p, int base, bit gaps);
        for (int i = first; i <= last_p; i++) send(d, base + i, gaps);
    endtask

    task automatic idle(int d);
        @(negedge clk);
        iv[d] = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
    endtask

    task automatic check_empty(string tag);
        check({tag, "_q0"}, exp_q0.size(), 0);
        check({tag, "_q1"}, exp_q1.size(), 0);
        check({tag, "_q2"}, exp_q2.size(), 0);
    endtask

    // Scoreboard: sampled just before the edge that completes each output handshake.
    always @(negedge clk) begin
        logic [256:0] got_w, exp_w;
        bit has7;
        #2;
        for (int d = 0; d < 3; d++) begin
            if (fd[d]) fd_cnt[d]++;
            if (ov[d] && ordy[d]) begin
                got_w = {ol[d], ow_of(d)};
                exp_w = '1;
                case (d)
                    0:       if (exp_q0.size() > 0) exp_w = exp_q0.pop_front();
                    1:       if (exp_q1.size() > 0) exp_w = exp_q1.pop_front();
                    default: if (exp_q2.size() > 0) exp_w = exp_q2.pop_front();
                endcase
                check($sformatf("win_d%0d_n%0d", d, win_idx[d]), got_w, exp_w);
                if (d == 0 && chk_last && ol[0])
                    check("basic_last_win", 257'(ow0), lit9('{60, 61, 62, 69, 70, 71, 78, 79, 80}));
                if (d == 1 && win_idx[1] == 7)
                    check("s1_win8", 257'(ow1), lit9('{9, 10, 11, 18, 19, 20, 27, 28, 29}));
                if (d == 2) begin
                    has7 = 0;
                    for (int e = 0; e < 16; e++) if (ow2[e*16 +: 16] % 8 == 7) has7 = 1;
                    check("d2_col7_absent", has7, 0);
                end
                win_idx[d]++;
            end
        end
        if (ov[1]) run1++;
        else if (run1 != 0) begin
            check("s1_row_run", run1, 7);
            run1 = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        bit found;
        iv = '0;
        ordy = 3'b111;
        ip = '{16'd0, 16'd0, 16'd0};
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_out_valid", ov[0], 0);
        check("rst_out_last", ol[0], 0);
        check("rst_frame_done", fd[0], 0);
        check("rst_out_window", 257'(ow0), 0);
        check("rst_in_ready", ir[0], 1);
        check("rst_fsm_fill", st0, 0);

        // basic stream with latency and frame_done timing
        chk_last = 1;
        fd0 = fd_cnt[0];
        push_frame(0, 9, 9, 3, 2, 0, -1);
        send_range(0, 0, 19, 0, 0);
        check("pre_first_valid", ov[0], 0);
        send(0, 20, 0);
        @(negedge clk);
        iv[0] = 1'b0;
        #1;
        check("first_latency", ov[0], 1);
        check("first_win", 257'(ow0), lit9('{0, 1, 2, 9, 10, 11, 18, 19, 20}));
        send_range(0, 21, 21, 0, 0);
        #5;
        send_range(0, 22, 22, 0, 0);
        @(negedge clk);
        iv[0] = 1'b0;
        #1;
        check("second_win", 257'(ow0), lit9('{2, 3, 4, 11, 12, 13, 20, 21, 22}));
        send_range(0, 23, 80, 0, 0);
        @(negedge clk);
        iv[0] = 1'b0;
        #1;
        check("frame_done_pulse", fd[0], 1);
        @(negedge clk);
        #1;
        check("frame_done_single", fd[0], 0);
        drain();
        check_empty("basic");
        check("basic_fd_count", fd_cnt[0] - fd0, 1);
        chk_last = 0;

        // backpressure on the first window
        push_frame(0, 9, 9, 3, 2, 0, -1);
        fork
            begin
                send_range(0, 0, 80, 0, 0);
                idle(0);
            end
            begin
                found = 0;
                for (int i = 0; i < 400 && !found; i++) begin
                    @(negedge clk);
                    if (ov[0]) begin
                        ordy[0] = 1'b0;
                        found = 1;
                    end
                end
                check("bp_found_window", found, 1);
                repeat (10) begin
                    @(negedge clk);
                    #1;
                    check("bp_in_ready_low", ir[0], 0);
                    check("bp_window_held", 257'(ow0), lit9('{0, 1, 2, 9, 10, 11, 18, 19, 20}));
                end
                @(negedge clk);
                ordy[0] = 1'b1;
            end
        join
        drain();
        check_empty("backpressure");

        // back-to-back frames A then B
        fd0 = fd_cnt[0];
        push_frame(0, 9, 9, 3, 2, 0, -1);
        push_frame(0, 9, 9, 3, 2, 100, -1);
        send_range(0, 0, 80, 0, 0);
        send_range(0, 0, 80, 100, 0);
        idle(0);
        drain();
        check_empty("b2b");
        check("b2b_fd_count", fd_cnt[0] - fd0, 2);

        // random in_valid gaps
        push_frame(0, 9, 9, 3, 2, 0, -1);
        send_range(0, 0, 80, 0, 1);
        idle(0);
        drain();
        check_empty("gaps");

        // reset after pixel 40, then a clean frame
        push_frame(0, 9, 9, 3, 2, 0, 6);
        send_range(0, 0, 40, 0, 0);
        @(negedge clk);
        iv[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_out_valid", ov[0], 0);
        check("mid_rst_out_window", 257'(ow0), 0);
        check("mid_rst_out_last", ol[0], 0);
        check("mid_rst_fsm", st0, 0);
        check_empty("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        push_frame(0, 9, 9, 3, 2, 0, -1);
        send_range(0, 0, 80, 0, 0);
        idle(0);
        drain();
        check_empty("post_rst");

        // stride 1
        push_frame(1, 9, 9, 3, 1, 0, -1);
        send_range(1, 0, 80, 0, 0);
        idle(1);
        drain();
        check_empty("stride1");
        check("s1_count", win_idx[1], 49);

        // odd geometry 8 wide, 10 high, K4, S3
        push_frame(2, 8, 10, 4, 3, 0, -1);
        send_range(2, 0, 79, 0, 0);
        idle(2);
        drain();
        check_empty("odd");
        check("odd_count", win_idx[2], 6);
        check("odd_fd_count", fd_cnt[2], 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
